bwn_layer_sequencer: RTL

- Controls the BWN inference datapath. One shared XNOR/accumulate engine is time-multiplexed across the four fully-connected layers (INPUT_SIZEn -> CLASS_NUMn).
- Counts incoming feature words from the UART interface into the input buffer.
- Then issues feature/weight read addresses, accumulator controls and result-write addresses layer by layer, using ping-pong activation banks.
- Sits between the UART interface output (d_o_valid) and the MAC engine / weight ROM / activation RAMs in the full design.

---
 rtl/bwn_pkg.sv | 28 ++
 rtl/bwn_layer_sequencer_if.sv | 52 +++++
 rtl/bwn_ctrl_pipe.sv | 54 +++++
 rtl/bwn_layer_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bwn_pkg.sv
// Shared types, default layer geometry and the weight-count helper for the BWN layer sequencer.
package bwn_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_LAYERS = 4;

    // Element l holds the value for layer_id l.
    typedef logic [NUM_LAYERS-1:0][31:0] layer_vec_t;

    localparam layer_vec_t CLASS_NUM  = {32'd3, 32'd40, 32'd80, 32'd120};
    localparam layer_vec_t INPUT_SIZE = {32'd40, 32'd80, 32'd120, 32'd1274};

    function automatic longint total_weights(input layer_vec_t cn, input layer_vec_t isz);
        longint sum;
        sum = 0;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            sum += longint'(cn[l]) * longint'(isz[l]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/bwn_layer_sequencer_if.sv
// Bus between the BWN layer sequencer and the UART front end / MAC engine / memories.
// cycle_cnt exists only when BWN_CYCLE_CNT_EN is defined.
interface bwn_layer_sequencer_if
    import bwn_pkg::*;
#(
    parameter int F_AW = 11,
    parameter int W_AW = 18
) ();

    // in_valid is a one-cycle strobe with no ready: a word is taken on every strobe
    // in LOAD and dropped (raising the sticky overrun) while busy.
    logic             in_valid;
    logic             in_wr_en;
    logic [F_AW-1:0]  in_wr_addr;
    logic [F_AW-1:0]  f_rd_addr;
    logic             f_rd_bank;
    logic [W_AW-1:0]  w_rd_addr;
    logic             acc_clr;
    logic             acc_en;
    logic             res_wr;
    logic [F_AW-1:0]  res_wr_addr;
    logic             res_last_layer;
    logic [1:0]       layer_id;
    logic             busy;
    logic             done;
    logic             overrun;
    state_t           dbg_state;
`ifdef BWN_CYCLE_CNT_EN
    logic [23:0]      cycle_cnt;
`endif

    modport master (
        input  in_valid,
        output in_wr_en, in_wr_addr, f_rd_addr, f_rd_bank, w_rd_addr,
        output acc_clr, acc_en, res_wr, res_wr_addr, res_last_layer,
        output layer_id, busy, done, overrun, dbg_state
`ifdef BWN_CYCLE_CNT_EN
        , output cycle_cnt
`endif
    );

    modport slave (
        output in_valid,
        input  in_wr_en, in_wr_addr, f_rd_addr, f_rd_bank, w_rd_addr,
        input  acc_clr, acc_en, res_wr, res_wr_addr, res_last_layer,
        input  layer_id, busy, done, overrun, dbg_state
`ifdef BWN_CYCLE_CNT_EN
        , input cycle_cnt
`endif
    );

endinterface

// File: rtl/bwn_ctrl_pipe.sv
// Alignment pipe for issue tags: accumulate controls leave at depth DEPTH-1 (with the read data),
// result writes leave at depth DEPTH, one cycle after the last accumulate of a neuron.
module bwn_ctrl_pipe #(
    parameter int DEPTH = 2,
    parameter int NW    = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic          i_first,
    input  logic          i_last,
    input  logic [NW-1:0] i_n,
    output logic          o_acc_en,
    output logic          o_acc_clr,
    output logic          o_res_wr,
    output logic [NW-1:0] o_res_n
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_last;
    // The first-flag is consumed at the accumulate tap, so it stops one stage early.
    logic [DEPTH-2:0] r_first;
    logic [NW-1:0]    r_n [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_last  <= '0;
            r_first <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_n[k] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_last[0]  <= i_last;
            r_first[0] <= i_first;
            r_n[0]     <= i_n;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_last[k]  <= r_last[k-1];
                r_n[k]     <= r_n[k-1];
            end
            for (int k = 1; k < DEPTH - 1; k++) begin
                r_first[k] <= r_first[k-1];
            end
        end
    end

    assign o_acc_en  = r_valid[DEPTH-2];
    assign o_acc_clr = r_valid[DEPTH-2] & r_first[DEPTH-2];
    assign o_res_wr  = r_valid[DEPTH-1] & r_last[DEPTH-1];
    assign o_res_n   = o_res_wr ? r_n[DEPTH-1] : '0;

endmodule

// File: rtl/bwn_layer_sequencer.sv
// Loads one feature frame, then time-multiplexes the shared XNOR/accumulate engine over four FC layers.
// Optional BWN_CYCLE_CNT_EN adds a cycle_cnt result on the bus, latched at each done.
module bwn_layer_sequencer
    import bwn_pkg::*;
#(
    parameter int CLASS_NUM1  = int'(CLASS_NUM[0]),
    parameter int CLASS_NUM2  = int'(CLASS_NUM[1]),
    parameter int CLASS_NUM3  = int'(CLASS_NUM[2]),
    parameter int CLASS_NUM4  = int'(CLASS_NUM[3]),
    parameter int INPUT_SIZE1 = int'(INPUT_SIZE[0]),
    parameter int INPUT_SIZE2 = int'(INPUT_SIZE[1]),
    parameter int INPUT_SIZE3 = int'(INPUT_SIZE[2]),
    parameter int INPUT_SIZE4 = int'(INPUT_SIZE[3]),
    parameter int RD_LAT      = 1,
    parameter int W_AW        = 18,
    parameter int F_AW        = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bwn_layer_sequencer_if.master bus
);

    localparam layer_vec_t CN_V  = {32'(CLASS_NUM4), 32'(CLASS_NUM3), 32'(CLASS_NUM2), 32'(CLASS_NUM1)};
    localparam layer_vec_t ISZ_V = {32'(INPUT_SIZE4), 32'(INPUT_SIZE3), 32'(INPUT_SIZE2), 32'(INPUT_SIZE1)};
    localparam longint TOTAL_W   = total_weights(CN_V, ISZ_V);
    localparam int DW            = $clog2(RD_LAT + 1);
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(RD_LAT);
    localparam logic [F_AW-1:0] IN_LAST    = F_AW'(INPUT_SIZE1 - 1);

    generate
        if (TOTAL_W > (longint'(1) << W_AW)) begin : g_bad_w_aw
            $error("bwn_layer_sequencer: W_AW cannot address the total weight count");
        end
        if (INPUT_SIZE1 > (1 << F_AW)) begin : g_bad_f_aw
            $error("bwn_layer_sequencer: F_AW cannot address INPUT_SIZE1 features");
        end
        if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
            $error("bwn_layer_sequencer: RD_LAT must be 1..3");
        end
    endgenerate

    state_t           r_state, w_state_nxt;
    logic [F_AW-1:0]  r_in_cnt, r_i, r_n;
    logic [W_AW-1:0]  r_wptr;
    logic [DW-1:0]    r_drain;
    logic [1:0]       r_layer;
    logic             r_bank, r_overrun, r_done;

    logic             w_load_acc, w_load_last, w_issue, w_busy;
    logic             w_i_first, w_i_last, w_n_last, w_drain_end;
    logic [F_AW-1:0]  w_isz_m1, w_cn_m1, w_res_n;
    logic             w_acc_en, w_acc_clr, w_res_wr;

    always_comb begin
        w_isz_m1    = F_AW'(ISZ_V[r_layer] - 32'd1);
        w_cn_m1     = F_AW'(CN_V[r_layer] - 32'd1);
        w_load_acc  = (r_state == LOAD) && bus.in_valid;
        w_load_last = w_load_acc && (r_in_cnt == IN_LAST);
        w_issue     = (r_state == RUN);
        w_busy      = (r_state == RUN) || (r_state == DRAIN);
        w_i_first   = (r_i == '0);
        w_i_last    = (r_i == w_isz_m1);
        w_n_last    = (r_n == w_cn_m1);
        w_drain_end = (r_state == DRAIN) && (r_drain == DRAIN_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD:    if (w_load_last) w_state_nxt = RUN;
            RUN:     if (w_i_last && w_n_last) w_state_nxt = DRAIN;
            DRAIN:   if (w_drain_end) w_state_nxt = (r_layer == 2'd3) ? DONE : RUN;
            DONE:    w_state_nxt = LOAD;
            default: w_state_nxt = LOAD;
        endcase
    end

    // The weight pointer runs across neurons and layers, so ROM addressing needs no multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_cnt  <= '0;
            r_i       <= '0;
            r_n       <= '0;
            r_wptr    <= '0;
            r_drain   <= '0;
            r_layer   <= '0;
            r_bank    <= 1'b0;
            r_overrun <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_load_acc) begin
                r_in_cnt <= w_load_last ? '0 : r_in_cnt + 1'b1;
            end
            if (bus.in_valid && w_busy) begin
                r_overrun <= 1'b1;
            end
            if (w_issue) begin
                r_wptr <= r_wptr + 1'b1;
                if (w_i_last) begin
                    r_i <= '0;
                    r_n <= w_n_last ? '0 : r_n + 1'b1;
                end else begin
                    r_i <= r_i + 1'b1;
                end
            end
            if (r_state == DRAIN) begin
                r_drain <= w_drain_end ? '0 : r_drain + 1'b1;
            end
            if (w_drain_end && (r_layer != 2'd3)) begin
                r_layer <= r_layer + 2'd1;
                r_bank  <= ~r_bank;
            end
            if (r_state == DONE) begin
                r_wptr  <= '0;
                r_layer <= '0;
                r_bank  <= 1'b0;
            end
            r_done <= (r_state == DONE);
        end
    end

    bwn_ctrl_pipe #(
        .DEPTH (RD_LAT + 1),
        .NW    (F_AW)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (w_issue),
        .i_first   (w_i_first),
        .i_last    (w_i_last),
        .i_n       (r_n),
        .o_acc_en  (w_acc_en),
        .o_acc_clr (w_acc_clr),
        .o_res_wr  (w_res_wr),
        .o_res_n   (w_res_n)
    );

`ifdef BWN_CYCLE_CNT_EN
    logic [23:0] r_run_cnt, r_cycle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt   <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_run_cnt <= (r_state == LOAD) ? '0 : r_run_cnt + 24'd1;
            if (r_state == DONE) begin
                r_cycle_cnt <= r_run_cnt + 24'd1;
            end
        end
    end

    assign bus.cycle_cnt = r_cycle_cnt;
`endif

    assign bus.in_wr_en       = w_load_acc;
    assign bus.in_wr_addr     = w_load_acc ? r_in_cnt : '0;
    assign bus.f_rd_addr      = w_issue ? r_i : '0;
    assign bus.f_rd_bank      = r_bank;
    assign bus.w_rd_addr      = w_issue ? r_wptr : '0;
    assign bus.acc_clr        = w_acc_clr;
    assign bus.acc_en         = w_acc_en;
    assign bus.res_wr         = w_res_wr;
    assign bus.res_wr_addr    = w_res_n;
    assign bus.res_last_layer = w_res_wr && (r_layer == 2'd3);
    assign bus.layer_id       = r_layer;
    assign bus.busy           = w_busy;
    assign bus.done           = r_done;
    assign bus.overrun        = r_overrun;
    assign bus.dbg_state      = r_state;

endmodule
